data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder on the processor's load/store interface.
- The datapath drives memr/memw, a byte address, and write data. This block latches the request, adds a programmable number of wait states, and performs the access on an internal word array.
- It returns read data with a one-cycle ready pulse, and holds a stall line high so the processor freezes its PC until the access completes.
- It flags misaligned, out-of-range and conflicting requests.

Parameters:
- ADDR_BITS, 8, log2 of word count; the array holds 2^ADDR_BITS 16-bit words.
- WAIT_CYCLES, 2, wait states between request capture and response (0..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- memr  input  1  read request.
- memw  input  1  write request.
- mem_address  input  16  byte address; bit 0 must be 0.
- mem_write_data  input  16  store data.
- memr_data  output  16  registered load data.
- mem_ready  output  1  one-cycle completion pulse.
- mem_stall  output  1  processor hold; PC and pipeline must not advance while high.
- mem_err  output  1  one-cycle error pulse, coincident with mem_ready.

Behaviour:
- Interface timing: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state IDLE, wait counter 0, memr_data 0, mem_ready 0, mem_err 0. Array contents are not cleared by reset.
- Word index is mem_address[ADDR_BITS:1].
- Error conditions, any of:
  - mem_address[0]=1 (misaligned);
  - mem_address[15:ADDR_BITS+1] != 0 (out of range);
  - memr=1 and memw=1 together.
- FSM IDLE:
  - mem_stall = memr|memw (combinational).
  - On a clock edge with memr|memw=1: latch op, address, write data and the error condition; load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- FSM WAIT:
  - mem_stall=1.
  - Inputs are ignored; the latched copy is used.
  - The counter decrements each edge; when it reaches 1, the next state is RESP.
- FSM RESP:
  - On the edge entering RESP, the access is performed:
    - write: mem[idx] <= data;
    - read: memr_data <= mem[idx].
  - In RESP: mem_ready=1, mem_stall=0, mem_err = latched error. Next state is IDLE unconditionally.
- Latency: request present in cycle n → stall high for cycles n..n+WAIT_CYCLES → mem_ready in cycle n+WAIT_CYCLES+1. The processor advances on the edge ending RESP.
- memr_data holds its value until the next successful read. Writes and errored accesses leave it unchanged.
- An errored access leaves the array and memr_data unmodified; timing is identical to a normal access.
- Back-to-back requests: an access can be accepted in the IDLE cycle immediately after RESP. Minimum spacing is WAIT_CYCLES+2 cycles.
- Reset asserted mid-access aborts immediately:
  - a write not yet committed is dropped;
  - outputs go to their reset values;
  - no ready pulse is produced.
- Read-after-write to the same address in consecutive accesses returns the new data.

Test Plan:
- WAIT_CYCLES=2; write 0xBEEF to 0x0010, then read 0x0010 → write: stall high 3 cycles, ready in 4th cycle, err=0; read: memr_data=0xBEEF at ready.
- WAIT_CYCLES=0 → request cycle n shows stall=1 for one cycle, ready=1 in cycle n+1; read of an unwritten-after-write location returns the last written value.
- Misaligned read at 0x0011 after a prior read returned 0x1234 → ready and err both pulse together, memr_data stays 0x1234; a subsequent read of 0x0010 is still correct.
- ADDR_BITS=8; write to 0x0200, memr=memw=1 at 0x0004 → both error, and mem[2] plus the word at the in-range alias 0x0000 are unchanged.
- Assert rst during WAIT of a write of 0x5555 to 0x0020 → state IDLE, ready/err/memr_data=0; a later read of 0x0020 returns the pre-write value.
- Inputs toggled during WAIT (address 0x0030 → 0x0040) → access uses the latched 0x0030.

Source files
------------

// File: rtl/data_mem_if.sv
// Load/store bus between the processor datapath and the data-memory responder.
interface data_mem_if;
  logic        memr;
  logic        memw;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] memr_data;
  logic        mem_ready;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output memr, memw, mem_address, mem_write_data,
    input  memr_data, mem_ready, mem_stall, mem_err
  );

  modport slave (
    input  memr, memw, mem_address, mem_write_data,
    output memr_data, mem_ready, mem_stall, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches a load/store, inserts WAIT_CYCLES wait states,
// then performs the access on a 16-bit word array with a one-cycle ready pulse.
module data_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          WORDS     = 1 << ADDR_BITS;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  // Misaligned, beyond the array, or both read and write at once.
  function automatic logic req_error(input logic r, input logic w, input logic [15:0] a);
    logic bad_s;
    bad_s = a[0] | ((a >> (ADDR_BITS + 1)) != 16'd0) | (r & w);
    return bad_s;
  endfunction

  state_t                 state_r, state_next_s;
  logic [3:0]             cnt_r, cnt_next_s;
  logic                   op_wr_r, op_rd_r, op_err_r;
  logic [ADDR_BITS-1:0]   idx_r;
  logic [15:0]            wdata_r;
  logic [15:0]            memr_data_r;
  logic                   ready_r, err_out_r;
  logic [15:0]            mem_r [0:WORDS-1];

  logic                   req_s, req_err_s, capture_s, stall_s;
  logic                   acc_go_s, acc_wr_s, acc_rd_s, acc_err_s;
  logic [ADDR_BITS-1:0]   acc_idx_s;
  logic [15:0]            acc_data_s;

  assign req_s     = bus.memr | bus.memw;
  assign req_err_s = req_error(bus.memr, bus.memw, bus.mem_address);

  // Next-state, stall and access-commit decode; acc_go_s marks the edge entering RESP.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    stall_s      = 1'b0;
    acc_go_s     = 1'b0;
    acc_wr_s     = op_wr_r;
    acc_rd_s     = op_rd_r;
    acc_err_s    = op_err_r;
    acc_idx_s    = idx_r;
    acc_data_s   = wdata_r;
    case (state_r)
      IDLE: begin
        stall_s = req_s;
        if (req_s) begin
          capture_s  = 1'b1;
          cnt_next_s = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            // No wait states: commit straight from the live request.
            state_next_s = RESP;
            acc_go_s     = 1'b1;
            acc_wr_s     = bus.memw;
            acc_rd_s     = bus.memr;
            acc_err_s    = req_err_s;
            acc_idx_s    = bus.mem_address[ADDR_BITS:1];
            acc_data_s   = bus.mem_write_data;
          end else begin
            state_next_s = WAIT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        stall_s    = 1'b1;
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_next_s = RESP;
          acc_go_s     = 1'b1;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Control state, request latch and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      op_wr_r     <= 1'b0;
      op_rd_r     <= 1'b0;
      op_err_r    <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= 16'd0;
      memr_data_r <= 16'd0;
      ready_r     <= 1'b0;
      err_out_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      ready_r   <= acc_go_s;
      err_out_r <= acc_go_s & acc_err_s;
      if (capture_s) begin
        op_wr_r  <= bus.memw;
        op_rd_r  <= bus.memr;
        op_err_r <= req_err_s;
        idx_r    <= bus.mem_address[ADDR_BITS:1];
        wdata_r  <= bus.mem_write_data;
      end
      if (acc_go_s && acc_rd_s && !acc_err_s) begin
        memr_data_r <= mem_r[acc_idx_s];
      end
    end
  end

  // Word array is not reset; a reset coinciding with the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && acc_go_s && acc_wr_s && !acc_err_s) begin
      mem_r[acc_idx_s] <= acc_data_s;
    end
  end

  assign bus.memr_data = memr_data_r;
  assign bus.mem_ready = ready_r;
  assign bus.mem_err   = err_out_r;
  assign bus.mem_stall = stall_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states and one with none.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  data_mem_if if2 ();
  data_mem_if if0 ();

  data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel0, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel0) begin
      if0.memr = r; if0.memw = w; if0.mem_address = a; if0.mem_write_data = d;
    end else begin
      if2.memr = r; if2.memw = w; if2.mem_address = a; if2.mem_write_data = d;
    end
  endtask

  // Holds the request until ready, optionally changing address/data once stalled.
  task automatic access(input bit sel0, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        input bit toggle, input logic [15:0] a2, input logic [15:0] d2,
                        output int stall_n, output int rdy_k,
                        output logic err, output logic [15:0] rd);
    int  k;
    bit  done;
    @(negedge clk);
    drive(sel0, r, w, a, d);
    stall_n = 0; rdy_k = -1; err = 1'b0; rd = 16'd0; done = 1'b0; k = 0;
    while (k < 40 && !done) begin
      #1;
      if (sel0 ? if0.mem_stall : if2.mem_stall) stall_n++;
      if (sel0 ? if0.mem_ready : if2.mem_ready) begin
        rdy_k = k;
        err   = sel0 ? if0.mem_err : if2.mem_err;
        rd    = sel0 ? if0.memr_data : if2.memr_data;
        done  = 1'b1;
      end else begin
        @(negedge clk);
        if (toggle && k == 0) drive(sel0, r, w, a2, d2);
        k++;
      end
    end
    check_eq("ready_seen", 32'(done), 32'd1);
    drive(sel0, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic xact(input string tag, input bit sel0, input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic exp_err, input logic [15:0] exp_rd);
    int stall_n, rdy_k;
    logic err;
    logic [15:0] rd;
    access(sel0, r, w, a, d, 1'b0, 16'd0, 16'd0, stall_n, rdy_k, err, rd);
    check_eq({tag, "_stall"}, 32'(stall_n), sel0 ? 32'd1 : 32'd3);
    check_eq({tag, "_lat"},   32'(rdy_k),   sel0 ? 32'd1 : 32'd3);
    check_eq({tag, "_err"},   32'(err),     32'(exp_err));
    check_eq({tag, "_data"},  32'(rd),      32'(exp_rd));
  endtask

  initial begin
    int stall_n, rdy_k, pulses;
    logic err;
    logic [15:0] rd;
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready2", 32'(if2.mem_ready), 32'd0);
    check_eq("rst_err2",   32'(if2.mem_err),   32'd0);
    check_eq("rst_data2",  32'(if2.memr_data), 32'd0);
    check_eq("rst_stall2", 32'(if2.mem_stall), 32'd0);
    check_eq("rst_ready0", 32'(if0.mem_ready), 32'd0);
    check_eq("rst_data0",  32'(if0.memr_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write then read with two wait states.
    xact("wr_beef", 1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
    xact("rd_beef", 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);

    // Zero wait states: latest write wins, errors still time normally.
    xact("w0_wr1", 1'b1, 1'b0, 1'b1, 16'h0008, 16'h1111, 1'b0, 16'h0000);
    xact("w0_rd1", 1'b1, 1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 16'h1111);
    xact("w0_wr2", 1'b1, 1'b0, 1'b1, 16'h0008, 16'h2222, 1'b0, 16'h1111);
    xact("w0_rd2", 1'b1, 1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 16'h2222);
    xact("w0_mis", 1'b1, 1'b1, 1'b0, 16'h0009, 16'h0000, 1'b1, 16'h2222);

    // Misaligned read keeps the previous load data.
    xact("wr_1234", 1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 16'hBEEF);
    xact("rd_1234", 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234);
    xact("rd_mis",  1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h1234);
    xact("rd_after",1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234);

    // Out-of-range write aliasing word 0 and a read+write conflict must both be dropped.
    xact("wr_aaaa", 1'b0, 1'b0, 1'b1, 16'h0004, 16'hAAAA, 1'b0, 16'h1234);
    xact("wr_5a5a", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5A5A, 1'b0, 16'h1234);
    xact("wr_oor",  1'b0, 1'b0, 1'b1, 16'h0200, 16'hDEAD, 1'b1, 16'h1234);
    xact("rw_both", 1'b0, 1'b1, 1'b1, 16'h0004, 16'h7777, 1'b1, 16'h1234);
    xact("rd_m2",   1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hAAAA);
    xact("rd_m0",   1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h5A5A);

    // Reset in the middle of a write's wait states.
    xact("wr_0f0f", 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0F0F, 1'b0, 16'h5A5A);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'h5555);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_eq("abort_state", 32'(dut2.state_r), 32'd0);
    check_eq("abort_ready", 32'(if2.mem_ready), 32'd0);
    check_eq("abort_err",   32'(if2.mem_err),   32'd0);
    check_eq("abort_data",  32'(if2.memr_data), 32'd0);
    check_eq("abort_stall", 32'(if2.mem_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (if2.mem_ready) pulses++;
    end
    check_eq("abort_pulses", 32'(pulses), 32'd0);
    xact("rd_0f0f", 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0F0F);

    // Inputs changed during wait states are ignored.
    xact("wr_3030", 1'b0, 1'b0, 1'b1, 16'h0030, 16'h3030, 1'b0, 16'h0F0F);
    xact("wr_4040", 1'b0, 1'b0, 1'b1, 16'h0040, 16'h4040, 1'b0, 16'h0F0F);
    access(1'b0, 1'b0, 1'b1, 16'h0030, 16'h9999, 1'b1, 16'h0040, 16'hEEEE,
           stall_n, rdy_k, err, rd);
    check_eq("tog_lat", 32'(rdy_k), 32'd3);
    check_eq("tog_err", 32'(err),   32'd0);
    xact("rd_9999", 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h9999);
    xact("rd_4040", 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h4040);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
